uart: RTL and testbench

Full-duplex UART peripheral with parameterised baud generation, oversampled receiver, transmitter and per-direction FIFOs. It sits between a system-clock bus-side client (request/ready handshakes) and the serial pins, with optional CTS/RTS flow control. 8N1 framing, LSB first.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_fifo.sv | 50 +++++
 rtl/uart.sv | 272 +++++++++++++++++++++++++++
 tb/tb_uart.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART: FSM state encodings, status bit
// positions and the baud divider computation.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_FRAME_ERR = 1;
    localparam int STATUS_OVERRUN   = 2;

    // System clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud, input int over_sample);
        return clk_freq / (baud * over_sample);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push on a full FIFO is taken
// only when a pop happens in the same cycle.
module uart_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART: shared oversample baud tick, oversampled receiver with
// FIFO and fall-through output register, FIFO-fed transmitter with CTS gating.
module uart
    import uart_pkg::*;
#(
    parameter int DataLength      = 8,
    parameter int FifoDepth       = 8,
    parameter int OverSample      = 8,
    parameter int BaudRate        = 115200,
    parameter int SystemClockFreq = 50_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_baud_clk,
    input  logic [7:0]            i_ctrl,
    output logic [7:0]            o_status,
    input  logic [DataLength-1:0] i_tx_data,
    input  logic                  i_tx_req,
    output logic [DataLength-1:0] o_rx_data,
    input  logic                  i_rx_req,
    output logic                  o_rx_rdy,
    input  logic                  i_rx,
    output logic                  o_tx,
    input  logic                  i_cts,
    output logic                  o_rts
);
    localparam int DIV = calc_div(SystemClockFreq, BaudRate, OverSample);
    localparam int DW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(OverSample);
    localparam int BW  = $clog2(DataLength);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OverSample - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OverSample / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DataLength - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;

    logic [1:0]            rx_sync;
    logic                  rx_line;
    rx_state_t             rx_state;
    logic [TW-1:0]         rx_tick_cnt;
    logic [BW-1:0]         rx_bit_cnt;
    logic [DataLength-1:0] rx_shift;
    logic                  rx_push;
    logic                  frame_err;
    logic                  rx_overrun;

    logic                  rx_full;
    logic                  rx_empty;
    logic [DataLength-1:0] rx_fifo_dout;
    logic                  rx_fifo_pop;
    logic                  rx_pop;
    logic                  rx_valid;
    logic [DataLength-1:0] rx_data;

    tx_state_t             tx_state;
    logic [TW-1:0]         tx_tick_cnt;
    logic [BW-1:0]         tx_bit_cnt;
    logic [DataLength-1:0] tx_shift;
    logic                  tx_out;
    logic                  tx_start;
    logic                  tx_empty;
    logic                  tx_full_unused;
    logic [DataLength-1:0] tx_fifo_dout;
    logic                  ctrl_unused;

    assign ctrl_unused = ^i_ctrl[7:1];

    assign tick       = (div_cnt == DIV_LAST);
    assign o_baud_clk = tick;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Resetting the synchronizer high keeps a reset release from looking like a start bit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], i_rx};
        end
    end
    assign rx_line = rx_sync[1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_state    <= RX_IDLE;
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_push     <= 1'b0;
            frame_err   <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            rx_push <= 1'b0;
            if (tick) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!rx_line) begin
                            rx_state    <= RX_START;
                            rx_tick_cnt <= '0;
                        end
                    end
                    RX_START: begin
                        if (rx_tick_cnt == TICK_HALF) begin
                            rx_tick_cnt <= '0;
                            rx_bit_cnt  <= '0;
                            rx_state    <= rx_line ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + TW'(1);
                        end
                    end
                    RX_DATA: begin
                        if (rx_tick_cnt == TICK_LAST) begin
                            rx_tick_cnt <= '0;
                            rx_shift    <= {rx_line, rx_shift[DataLength-1:1]};
                            if (rx_bit_cnt == BIT_LAST) begin
                                rx_state <= RX_STOP;
                            end else begin
                                rx_bit_cnt <= rx_bit_cnt + BW'(1);
                            end
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + TW'(1);
                        end
                    end
                    RX_STOP: begin
                        if (rx_tick_cnt == TICK_LAST) begin
                            rx_state <= RX_IDLE;
                            if (rx_line) begin
                                rx_push <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + TW'(1);
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
            if (rx_push && rx_full && !rx_fifo_pop) begin
                rx_overrun <= 1'b1;
            end
        end
    end

    uart_fifo #(
        .Width(DataLength),
        .Depth(FifoDepth)
    ) u_rx_fifo (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .push (rx_push),
        .pop  (rx_fifo_pop),
        .din  (rx_shift),
        .dout (rx_fifo_dout),
        .full (rx_full),
        .empty(rx_empty)
    );

    // The output register refills from the FIFO in the same cycle it is popped.
    assign rx_pop      = i_rx_req && rx_valid;
    assign rx_fifo_pop = !rx_empty && (!rx_valid || rx_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (rx_fifo_pop) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_fifo_dout;
        end else if (rx_pop) begin
            rx_valid <= 1'b0;
        end
    end

    assign o_rx_rdy  = rx_valid;
    assign o_rx_data = rx_data;
    assign o_rts     = rx_full;

    always_comb begin
        o_status                   = '0;
        o_status[STATUS_BUSY]      = (rx_state != RX_IDLE);
        o_status[STATUS_FRAME_ERR] = frame_err;
        o_status[STATUS_OVERRUN]   = rx_overrun;
    end

    uart_fifo #(
        .Width(DataLength),
        .Depth(FifoDepth)
    ) u_tx_fifo (
        .clk  (i_clk),
        .rst_n(i_rst_n),
        .push (i_tx_req),
        .pop  (tx_start),
        .din  (i_tx_data),
        .dout (tx_fifo_dout),
        .full (tx_full_unused),
        .empty(tx_empty)
    );

    // CTS only gates the start of a frame; a frame already on the wire always finishes.
    assign tx_start = (tx_state == TX_IDLE) && tick && !tx_empty && (!i_ctrl[0] || !i_cts);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state    <= TX_IDLE;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            tx_out      <= 1'b1;
        end else if (tick) begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_start) begin
                        tx_state    <= TX_START;
                        tx_shift    <= tx_fifo_dout;
                        tx_tick_cnt <= '0;
                        tx_out      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick_cnt == TICK_LAST) begin
                        tx_state    <= TX_DATA;
                        tx_tick_cnt <= '0;
                        tx_bit_cnt  <= '0;
                        tx_out      <= tx_shift[0];
                        tx_shift    <= {1'b0, tx_shift[DataLength-1:1]};
                    end else begin
                        tx_tick_cnt <= tx_tick_cnt + TW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_tick_cnt == TICK_LAST) begin
                        tx_tick_cnt <= '0;
                        if (tx_bit_cnt == BIT_LAST) begin
                            tx_state <= TX_STOP;
                            tx_out   <= 1'b1;
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + BW'(1);
                            tx_out     <= tx_shift[0];
                            tx_shift   <= {1'b0, tx_shift[DataLength-1:1]};
                        end
                    end else begin
                        tx_tick_cnt <= tx_tick_cnt + TW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_tick_cnt == TICK_LAST) begin
                        tx_state    <= TX_IDLE;
                        tx_tick_cnt <= '0;
                    end else begin
                        tx_tick_cnt <= tx_tick_cnt + TW'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign o_tx = tx_out;

endmodule

// File: tb/tb_uart.sv
// Directed bench for the UART: table-driven receive frames plus hand-written
// sequences for glitch rejection, reset, FIFO overrun/RTS and CTS-gated transmit.
module tb_uart;

    localparam int BitClocks   = 434;
    localparam int TxBitClocks = 432;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_rdy;
        logic [7:0] exp_data;
        logic [7:0] exp_status;
    } rx_vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_clk;
    logic [7:0] ctrl = 8'h00;
    logic [7:0] status;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req = 1'b0;
    logic [7:0] rx_data;
    logic       rx_req = 1'b0;
    logic       rx_rdy;
    logic       rx_line = 1'b1;
    logic       tx_line;
    logic       cts = 1'b0;
    logic       rts;

    int checks = 0;
    int failures = 0;

    rx_vec_t    vecs [8];
    logic [7:0] fill_bytes [10];

    uart dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .o_baud_clk(baud_clk),
        .i_ctrl    (ctrl),
        .o_status  (status),
        .i_tx_data (tx_data),
        .i_tx_req  (tx_req),
        .o_rx_data (rx_data),
        .i_rx_req  (rx_req),
        .o_rx_rdy  (rx_rdy),
        .i_rx      (rx_line),
        .o_tx      (tx_line),
        .i_cts     (cts),
        .o_rts     (rts)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one serial frame on i_rx at BitClocks per bit, LSB first.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        rx_line = 1'b0;
        repeat (BitClocks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = data[i];
            repeat (BitClocks) @(negedge clk);
        end
        rx_line = stop_bit;
        repeat (BitClocks) @(negedge clk);
        rx_line = 1'b1;
    endtask

    task automatic waitRxIdle();
        for (int i = 0; i < 1000 && status[0]; i++) @(negedge clk);
        checkOutput("rx_idle", {31'b0, status[0]}, 32'd0);
    endtask

    task automatic popWord(input logic [7:0] expected, input int idx);
        checkOutput($sformatf("fill_rdy[%0d]", idx), {31'b0, rx_rdy}, 32'd1);
        checkOutput($sformatf("fill_data[%0d]", idx), {24'b0, rx_data}, {24'b0, expected});
        rx_req = 1'b1;
        @(negedge clk);
        rx_req = 1'b0;
    endtask

    initial begin
        int  tick_count;
        logic busy_seen;

        vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 8'h00};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 8'h00};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 8'h00};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 8'h00};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 8'h00};
        vecs[6] = '{8'h6B, 1'b1, 1'b1, 8'h6B, 8'h00};
        vecs[7] = '{8'h55, 1'b0, 1'b0, 8'h6B, 8'h02};
        fill_bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

        repeat (5) @(negedge clk);
        checkOutput("reset_tx", {31'b0, tx_line}, 32'd1);
        checkOutput("reset_rdy", {31'b0, rx_rdy}, 32'd0);
        checkOutput("reset_data", {24'b0, rx_data}, 32'd0);
        checkOutput("reset_status", {24'b0, status}, 32'd0);
        checkOutput("reset_rts", {31'b0, rts}, 32'd0);
        checkOutput("reset_baud", {31'b0, baud_clk}, 32'd0);
        rst_n = 1'b1;

        tick_count = 0;
        repeat (540) begin
            @(negedge clk);
            if (baud_clk) tick_count++;
        end
        checkOutput("baud_ticks_540", tick_count, 32'd10);

        for (int r = 0; r < 8; r++) begin
            applyStimulus(vecs[r].data, vecs[r].stop_bit);
            waitRxIdle();
            checkOutput($sformatf("rx_rdy[%0d]", r), {31'b0, rx_rdy}, {31'b0, vecs[r].exp_rdy});
            checkOutput($sformatf("rx_data[%0d]", r), {24'b0, rx_data}, {24'b0, vecs[r].exp_data});
            checkOutput($sformatf("status[%0d]", r), {24'b0, status}, {24'b0, vecs[r].exp_status});
            if (vecs[r].exp_rdy) begin
                rx_req = 1'b1;
                @(negedge clk);
                rx_req = 1'b0;
                checkOutput($sformatf("rdy_after_pop[%0d]", r), {31'b0, rx_rdy}, 32'd0);
                checkOutput($sformatf("data_held[%0d]", r), {24'b0, rx_data}, {24'b0, vecs[r].exp_data});
            end
        end

        busy_seen = 1'b0;
        rx_line = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (i == 100) rx_line = 1'b1;
            @(negedge clk);
            if (status[0]) busy_seen = 1'b1;
        end
        checkOutput("glitch_busy_seen", {31'b0, busy_seen}, 32'd1);
        waitRxIdle();
        checkOutput("glitch_no_rdy", {31'b0, rx_rdy}, 32'd0);
        checkOutput("glitch_status", {24'b0, status}, 32'h02);

        rx_line = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("midframe_status", {24'b0, status}, 32'h03);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        checkOutput("midreset_status", {24'b0, status}, 32'h00);
        checkOutput("midreset_rdy", {31'b0, rx_rdy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        fork
            begin
                for (int i = 0; i < 9; i++) applyStimulus(fill_bytes[i], 1'b1);
                checkOutput("rts_full", {31'b0, rts}, 32'd1);
                checkOutput("status_before_overrun", {24'b0, status}, 32'h00);
                applyStimulus(fill_bytes[9], 1'b1);
                checkOutput("status_overrun", {24'b0, status}, 32'h04);
                checkOutput("rts_still_full", {31'b0, rts}, 32'd1);
                for (int i = 0; i < 9; i++) begin
                    popWord(fill_bytes[i], i);
                    if (i == 0) checkOutput("rts_after_pop", {31'b0, rts}, 32'd0);
                end
                checkOutput("fill_drained", {31'b0, rx_rdy}, 32'd0);
            end
            begin
                logic [7:0] tx_byte;
                logic       low_seen;
                logic       found;
                logic       exp_bit;
                tx_byte = 8'h96;
                ctrl = 8'h01;
                cts = 1'b1;
                tx_data = tx_byte;
                tx_req = 1'b1;
                @(negedge clk);
                tx_req = 1'b0;
                low_seen = 1'b0;
                repeat (1500) begin
                    @(negedge clk);
                    if (!tx_line) low_seen = 1'b1;
                end
                checkOutput("tx_held_by_cts", {31'b0, low_seen}, 32'd0);
                cts = 1'b0;
                found = 1'b0;
                for (int i = 0; i < 200 && !found; i++) begin
                    @(negedge clk);
                    if (!tx_line) found = 1'b1;
                end
                checkOutput("tx_start_seen", {31'b0, found}, 32'd1);
                if (found) begin
                    for (int k = 0; k < 10; k++) begin
                        if (k == 0) exp_bit = 1'b0;
                        else if (k == 9) exp_bit = 1'b1;
                        else exp_bit = tx_byte[k-1];
                        @(negedge clk);
                        checkOutput($sformatf("tx_bit%0d_early", k), {31'b0, tx_line}, {31'b0, exp_bit});
                        repeat (TxBitClocks - 3) @(negedge clk);
                        checkOutput($sformatf("tx_bit%0d_late", k), {31'b0, tx_line}, {31'b0, exp_bit});
                        repeat (2) @(negedge clk);
                    end
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
